// File: rtl/lfsr_seq_ctrl.sv
// Round-robin sequencer sharing one external LFSR between two requesters: seed, then stream len+1 words.
// Optional abort input is compiled in with `define LFSR_SEQ_CTRL_ABORT_EN.
module lfsr_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic [7:0]       len0,
    input  logic [7:0]       len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] lfsr_data,
    output logic             lfsr_load_n,
    output logic             lfsr_cen,
    input  logic [WIDTH-1:0] lfsr_count,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef LFSR_SEQ_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEED,
        S_RUN
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_gnt;
    logic             r_idx;
    logic             r_ptr;
    logic [WIDTH-1:0] r_seed_cap;
    logic [7:0]       r_len_cap;
    logic [7:0]       r_cnt;

    logic             w_any_req;
    logic             w_sel;
    logic [WIDTH-1:0] w_seed_sel;
    logic [7:0]       w_len_sel;
    logic             w_abort;
    logic             w_fire;
    logic             w_end;

`ifdef LFSR_SEQ_CTRL_ABORT_EN
    // Abort only has meaning while a burst owns the LFSR.
    assign w_abort = abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // r_ptr names the requester that wins a tie; it points away from the last one served.
    assign w_any_req  = |req;
    assign w_sel      = req[r_ptr] ? r_ptr : ~r_ptr;
    assign w_seed_sel = w_sel ? seed1 : seed0;
    assign w_len_sel  = w_sel ? len1 : len0;

    assign w_fire = (r_state == S_RUN) && out_ready && !w_abort;
    assign w_end  = (w_fire && (r_cnt == 8'd0)) || w_abort;

    // State register; the active-high level on rst_n is the asynchronous reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: if (w_any_req) w_next_state = S_SEED;
            S_SEED: w_next_state = w_abort ? S_IDLE : S_RUN;
            S_RUN:  if (w_end) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_gnt      <= 2'b00;
            r_idx      <= 1'b0;
            r_ptr      <= 1'b0;
            r_seed_cap <= '0;
            r_len_cap  <= 8'd0;
            r_cnt      <= 8'd0;
        end else begin
            if ((r_state == S_IDLE) && w_any_req) begin
                r_idx      <= w_sel;
                r_gnt      <= w_sel ? 2'b10 : 2'b01;
                // An all-zero seed would lock the LFSR up.
                r_seed_cap <= (w_seed_sel == '0) ? WIDTH'(1) : w_seed_sel;
                r_len_cap  <= w_len_sel;
            end
            if (r_state == S_SEED) begin
                r_cnt <= r_len_cap;
            end else if (w_fire && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_end) begin
                r_gnt <= 2'b00;
                r_ptr <= ~r_idx;
            end
        end
    end

    always_comb begin
        gnt         = r_gnt;
        out_id      = r_idx;
        out_data    = lfsr_count;
        out_valid   = (r_state == S_RUN) && !w_abort;
        out_last    = out_valid && (r_cnt == 8'd0);
        lfsr_cen    = out_valid && out_ready;
        lfsr_load_n = (r_state != S_SEED);
        // The LFSR loads data XOR count, so pre-XOR the seed with the current count.
        lfsr_data   = (r_state == S_SEED) ? (r_seed_cap ^ lfsr_count) : '0;
        done        = 2'b00;
        if (w_end) done = r_idx ? 2'b10 : 2'b01;
    end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a behavioural shift-left XNOR LFSR standing in for the shared LFSR.
// Also exercises the abort input when LFSR_SEQ_CTRL_ABORT_EN is defined.
module tb_lfsr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] seed0, seed1, len0, len1;
    logic [1:0] gnt, done;
    logic [7:0] lfsr_data;
    logic       lfsr_load_n, lfsr_cen;
    logic [7:0] lfsr_count = 8'hA5;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic       out_id, out_last;
`ifdef LFSR_SEQ_CTRL_ABORT_EN
    logic       abort = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lfsr_seq_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .seed0      (seed0),
        .seed1      (seed1),
        .len0       (len0),
        .len1       (len1),
        .gnt        (gnt),
        .done       (done),
        .lfsr_data  (lfsr_data),
        .lfsr_load_n(lfsr_load_n),
        .lfsr_cen   (lfsr_cen),
        .lfsr_count (lfsr_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef LFSR_SEQ_CTRL_ABORT_EN
        .abort      (abort),
`endif
        .out_data   (out_data),
        .out_id     (out_id),
        .out_last   (out_last)
    );

    // External LFSR: 0x01 -> 0x03 -> 0x07 -> 0x0F ...
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ~(q[7] ^ q[5] ^ q[4] ^ q[3])};
    endfunction

    always @(posedge clk) begin
        if (!lfsr_load_n)  lfsr_count <= lfsr_count ^ lfsr_data;
        else if (lfsr_cen) lfsr_count <= lfsr_next(lfsr_count);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " valid"},  32'(out_valid),   32'd0);
        check({tag, " gnt"},    32'(gnt),         32'd0);
        check({tag, " done"},   32'(done),        32'd0);
        check({tag, " last"},   32'(out_last),    32'd0);
        check({tag, " load_n"}, 32'(lfsr_load_n), 32'd1);
        check({tag, " cen"},    32'(lfsr_cen),    32'd0);
        check({tag, " ldata"},  32'(lfsr_data),   32'd0);
    endtask

    task automatic word(input string tag, input logic [7:0] data, input logic id,
                        input logic last, input logic [1:0] dn);
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " data"},  32'(out_data),  32'(data));
        check({tag, " id"},    32'(out_id),    32'(id));
        check({tag, " last"},  32'(out_last),  32'(last));
        check({tag, " done"},  32'(done),      32'(dn));
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; out_ready = 1'b0;
        seed0 = 8'h00; seed1 = 8'h00; len0 = 8'd0; len1 = 8'd0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        req = 2'b01;
        #1;
        check_idle("reset");
        check("reset id", 32'(out_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b0; req = 2'b00;

        // Basic burst, len0=2; inputs changed after capture must not matter.
        req = 2'b01; seed0 = 8'h01; len0 = 8'd2; out_ready = 1'b1;
        tick();
        check("t1 seed gnt",    32'(gnt),         32'h1);
        check("t1 seed load_n", 32'(lfsr_load_n), 32'd0);
        check("t1 seed ldata",  32'(lfsr_data),   32'hA4);
        check("t1 seed valid",  32'(out_valid),   32'd0);
        check("t1 seed cen",    32'(lfsr_cen),    32'd0);
        seed0 = 8'hFF; len0 = 8'd7;
        tick(); word("t1 w0", 8'h01, 1'b0, 1'b0, 2'b00);
        check("t1 w0 cen", 32'(lfsr_cen), 32'd1);
        tick(); word("t1 w1", 8'h03, 1'b0, 1'b0, 2'b00);
        tick(); word("t1 w2", 8'h07, 1'b0, 1'b1, 2'b01);
        req = 2'b00;
        tick(); check_idle("t1 end");
        seed0 = 8'h01; len0 = 8'd2;

        // Back-pressure for three cycles on the second word; LFSR sits at 0x0F.
        req = 2'b01;
        tick();
        check("t2 seed ldata", 32'(lfsr_data), 32'h0E);
        tick(); word("t2 w0", 8'h01, 1'b0, 1'b0, 2'b00);
        tick(); word("t2 w1", 8'h03, 1'b0, 1'b0, 2'b00);
        out_ready = 1'b0; #1;
        check("t2 stall0 cen", 32'(lfsr_cen), 32'd0);
        tick(); word("t2 stall1", 8'h03, 1'b0, 1'b0, 2'b00);
        check("t2 stall1 cen", 32'(lfsr_cen), 32'd0);
        tick(); word("t2 stall2", 8'h03, 1'b0, 1'b0, 2'b00);
        tick(); word("t2 stall3", 8'h03, 1'b0, 1'b0, 2'b00);
        out_ready = 1'b1; #1;
        check("t2 resume cen", 32'(lfsr_cen), 32'd1);
        tick(); word("t2 w2", 8'h07, 1'b0, 1'b1, 2'b01);
        req = 2'b00;
        tick(); check_idle("t2 end");

        // Round robin from reset with both requesting, len=0.
        rst_n = 1'b1; #1; rst_n = 1'b0;
        req = 2'b11; seed0 = 8'h11; seed1 = 8'h22; len0 = 8'd0; len1 = 8'd0;
        tick(); check("t3 a gnt", 32'(gnt), 32'h1);
        tick(); word("t3 a", 8'h11, 1'b0, 1'b1, 2'b01);
        tick(); check_idle("t3 gap1");
        tick(); check("t3 b gnt", 32'(gnt), 32'h2);
        tick(); word("t3 b", 8'h22, 1'b1, 1'b1, 2'b10);
        tick(); check("t3 gap2 valid", 32'(out_valid), 32'd0);
        tick(); check("t3 c gnt", 32'(gnt), 32'h1);
        tick(); word("t3 c", 8'h11, 1'b0, 1'b1, 2'b01);
        req = 2'b00;
        tick(); check_idle("t3 end");

        // Zero seed on requester 1 is replaced by 0x01.
        req = 2'b10; seed1 = 8'h00; len1 = 8'd1;
        tick(); check("t4 gnt", 32'(gnt), 32'h2);
        tick(); word("t4 w0", 8'h01, 1'b1, 1'b0, 2'b00);
        tick(); word("t4 w1", 8'h03, 1'b1, 1'b1, 2'b10);
        req = 2'b00;
        tick(); check_idle("t4 end");

        // Reset during the second word abandons the burst silently.
        req = 2'b01; seed0 = 8'h01; len0 = 8'd2;
        tick(); tick();
        tick(); word("t5 w1", 8'h03, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b1; #1;
        check_idle("t5 rst");
        check("t5 rst id", 32'(out_id), 32'd0);
        tick(); check_idle("t5 held");
        rst_n = 1'b0; #1;
        check_idle("t5 idle");
        tick(); check("t5 seed gnt", 32'(gnt), 32'h1);
        tick(); word("t5 w0", 8'h01, 1'b0, 1'b0, 2'b00);
        tick(); tick(); word("t5 w2", 8'h07, 1'b0, 1'b1, 2'b01);
        req = 2'b00;
        tick(); check_idle("t5 end");

`ifdef LFSR_SEQ_CTRL_ABORT_EN
        // Abort on the first RUN cycle of a long burst.
        abort = 1'b1;
        tick(); check_idle("t6 idle abort");
        req = 2'b01; seed0 = 8'h01; len0 = 8'd5; abort = 1'b0;
        tick(); tick();
        abort = 1'b1; #1;
        check("t6 done", 32'(done),     32'h1);
        check("t6 cen",  32'(lfsr_cen), 32'd0);
        req = 2'b00;
        tick(); abort = 1'b0; #1;
        check_idle("t6 end");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
